// File: rtl/div_ctrl_if.sv
// Handshake between the EX stage (master) and the multi-cycle divider (slave).
// EX holds start_i with the operands until it has consumed ready_o/result_o.
interface div_ctrl_if #(
   parameter int WIDTH = 32
);
   logic               signed_div_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               start_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock, signed
// operands handled as magnitudes with a sign fix-up on the final iteration.
module div_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic       clk,
   input logic       rst,
   div_ctrl_if.slave bus
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic [WIDTH-1:0]   dividend;   // shifts left; quotient bits enter at the LSB
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   rem;
   logic               neg_quot;
   logic               neg_rem;
   logic [2*WIDTH-1:0] result;
   logic               ready;

   logic [WIDTH-1:0]   op1_mag;
   logic [WIDTH-1:0]   op2_mag;
   logic               op1_neg;
   logic               op2_neg;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     trial;
   logic               q_bit;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quot_next;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [CNT_W-1:0]   count_next;
   logic               last_iter;

   assign op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
   assign op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
   assign op1_mag = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
   assign op2_mag = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

   // rem < divisor before the shift, so the shifted value is below 2*divisor and
   // the MSB of the (WIDTH+1)-bit difference is exactly the borrow.
   assign rem_shift  = {rem, dividend[WIDTH-1]};
   assign trial      = rem_shift - {1'b0, divisor};
   assign q_bit      = ~trial[WIDTH];
   assign rem_next   = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
   assign quot_next  = {dividend[WIDTH-2:0], q_bit};
   assign quot_fix   = neg_quot ? -quot_next : quot_next;
   assign rem_fix    = neg_rem ? -rem_next : rem_next;
   assign count_next = counter + 1'b1;
   assign last_iter  = (count_next == CNT_W'(WIDTH));

   assign bus.result_o = result;
   assign bus.ready_o  = ready;

   // NOTE: every register here is state, so only non-blocking assignments are
   // used; the working registers are cleared on reset too so an aborted
   // division leaves no residue visible to the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FREE;
         counter  <= '0;
         dividend <= '0;
         divisor  <= '0;
         rem      <= '0;
         neg_quot <= 1'b0;
         neg_rem  <= 1'b0;
         result   <= '0;
         ready    <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               ready  <= 1'b0;
               result <= '0;
               if (bus.start_i && !bus.annul_i) begin
                  if (bus.opdata2_i == '0) begin
                     state <= BYZERO;
                  end else begin
                     state    <= ON;
                     dividend <= op1_mag;
                     divisor  <= op2_mag;
                     neg_quot <= op1_neg ^ op2_neg;
                     neg_rem  <= op1_neg;
                     rem      <= '0;
                     counter  <= '0;
                  end
               end
            end

            BYZERO: begin
               if (bus.annul_i) begin
                  state <= FREE;
               end else begin
                  state  <= END;
                  result <= '0;
                  ready  <= 1'b1;
               end
            end

            ON: begin
               if (bus.annul_i) begin
                  state   <= FREE;
                  counter <= '0;
               end else begin
                  rem      <= rem_next;
                  dividend <= quot_next;
                  counter  <= count_next;
                  if (last_iter) begin
                     state  <= END;
                     result <= {rem_fix, quot_fix};
                     ready  <= 1'b1;
                  end
               end
            end

            END: begin
               // The result is complete, so annul no longer matters here.
               if (!bus.start_i) begin
                  state  <= FREE;
                  ready  <= 1'b0;
                  result <= '0;
               end
            end

            default: state <= FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, signed fix-up, overflow, divide-by-zero,
// annul, reset mid-division and back-to-back operation with hand-computed results.
module tb_div_ctrl;

   localparam int WIDTH = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   div_ctrl_if #(.WIDTH(WIDTH)) bus ();

   div_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a request just after an edge, then let the start edge (E0) pass.
   task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      @(posedge clk); #1;
   endtask

   // Count edges after E0 until ready_o rises, bounded by limit.
   task automatic wait_ready(input int limit, output int edges);
      edges = 0;
      while (!bus.ready_o && edges < limit) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.start_i = 1'b1;
      bus.opdata1_i = 32'd5;
      bus.opdata2_i = 32'd1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 0", bus.ready_o);
      end
      checks++;
      if (bus.result_o !== 64'h0) begin
         errors++;
         $display("FAIL reset_result: got %h expected 0", bus.result_o);
      end
      bus.start_i = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned;
      int edges;
      start_div(1'b0, 32'd100, 32'd7);
      wait_ready(40, edges);
      checks++;
      if (edges !== 32) begin
         errors++;
         $display("FAIL divu_latency: got %0d edges expected 32", edges);
      end
      checks++;
      if (bus.result_o !== {32'h2, 32'hE}) begin
         errors++;
         $display("FAIL divu_100_7: got %h expected %h", bus.result_o, {32'h2, 32'hE});
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.ready_o !== 1'b1 || bus.result_o !== {32'h2, 32'hE}) begin
            errors++;
            $display("FAIL divu_hold: got ready=%b result=%h expected ready=1 result=%h",
                     bus.ready_o, bus.result_o, {32'h2, 32'hE});
         end
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         errors++;
         $display("FAIL divu_release: got ready=%b result=%h expected ready=0 result=0",
                  bus.ready_o, bus.result_o);
      end
   endtask

   task automatic test_signed;
      int edges;
      start_div(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_ready(40, edges);
      checks++;
      if (edges !== 32 || bus.result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
         errors++;
         $display("FAIL div_m7_2: got %0d edges result=%h expected 32 edges result=%h",
                  edges, bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      start_div(1'b1, 32'd7, 32'hFFFF_FFFE);
      wait_ready(40, edges);
      checks++;
      if (edges !== 32 || bus.result_o !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
         errors++;
         $display("FAIL div_7_m2: got %0d edges result=%h expected 32 edges result=%h",
                  edges, bus.result_o, {32'h0000_0001, 32'hFFFF_FFFD});
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_overflow_byzero;
      int edges;
      start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_ready(40, edges);
      checks++;
      if (edges !== 32 || bus.result_o !== {32'h0, 32'h8000_0000}) begin
         errors++;
         $display("FAIL div_overflow: got %0d edges result=%h expected 32 edges result=%h",
                  edges, bus.result_o, {32'h0, 32'h8000_0000});
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      // Zero divisor: ready one edge after the start edge (two edges in total).
      start_div(1'b0, 32'd1234, 32'd0);
      checks++;
      if (bus.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL byzero_early: got ready=%b expected 0 after start edge", bus.ready_o);
      end
      wait_ready(40, edges);
      checks++;
      if (edges !== 1 || bus.result_o !== 64'h0) begin
         errors++;
         $display("FAIL byzero: got %0d edges result=%h expected 1 edge result=0",
                  edges, bus.result_o);
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL byzero_release: got ready=%b expected 0", bus.ready_o);
      end
   endtask

   task automatic test_annul;
      int  edges;
      logic seen;
      start_div(1'b0, 32'hFFFF_FFFF, 32'd3);
      repeat (10) @(posedge clk);
      #1;
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      bus.annul_i = 1'b0;
      seen = bus.ready_o;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         seen = seen | bus.ready_o;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL annul_no_ready: got ready seen=%b expected 0", seen);
      end
      start_div(1'b0, 32'd9, 32'd3);
      wait_ready(40, edges);
      checks++;
      if (edges !== 32 || bus.result_o !== {32'h0, 32'h3}) begin
         errors++;
         $display("FAIL annul_then_9_3: got %0d edges result=%h expected 32 edges result=%h",
                  edges, bus.result_o, {32'h0, 32'h3});
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int edges;
      start_div(1'b0, 32'h1234_5678, 32'd3);
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
         errors++;
         $display("FAIL reset_mid: got ready=%b result=%h expected ready=0 result=0",
                  bus.ready_o, bus.result_o);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      start_div(1'b0, 32'd50, 32'd5);
      wait_ready(40, edges);
      checks++;
      if (edges !== 32 || bus.result_o !== {32'h0, 32'hA}) begin
         errors++;
         $display("FAIL reset_then_50_5: got %0d edges result=%h expected 32 edges result=%h",
                  edges, bus.result_o, {32'h0, 32'hA});
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int edges;
      start_div(1'b0, 32'd10, 32'd3);
      wait_ready(40, edges);
      checks++;
      if (edges !== 32 || bus.result_o !== {32'h1, 32'h3}) begin
         errors++;
         $display("FAIL b2b_10_3: got %0d edges result=%h expected 32 edges result=%h",
                  edges, bus.result_o, {32'h1, 32'h3});
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.ready_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: got ready=%b expected 0", bus.ready_o);
      end
      start_div(1'b0, 32'd11, 32'd4);
      repeat (5) @(posedge clk);
      #1;
      // Operands and mode change mid-division must have no effect.
      bus.opdata1_i    = 32'hDEAD_BEEF;
      bus.opdata2_i    = 32'd0;
      bus.signed_div_i = 1'b1;
      wait_ready(40, edges);
      checks++;
      if (edges !== 27 || bus.result_o !== {32'h3, 32'h2}) begin
         errors++;
         $display("FAIL b2b_11_4: got %0d remaining edges result=%h expected 27 edges result=%h",
                  edges, bus.result_o, {32'h3, 32'h2});
      end
      bus.start_i = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      test_reset();
      test_unsigned();
      test_signed();
      test_overflow_byzero();
      test_annul();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
